// File: rtl/projection_frame_scheduler_pkg.sv
// Shared definitions for the projection frame scheduler.
//   - Default frame geometry, so the wrapper, the math unit and the scheduler agree.
//   - Bank-state encodings (legacy 2-bit constants) and small state predicates.
package projection_frame_scheduler_pkg;

    localparam int unsigned DEF_WIDTH  = 1080;
    localparam int unsigned DEF_HEIGHT = 960;

    typedef logic [1:0] bank_state_t;

    localparam bank_state_t EMPTY   = 2'd0;
    localparam bank_state_t FILLING = 2'd1;
    localparam bank_state_t FULL    = 2'd2;
    localparam bank_state_t READING = 2'd3;

    // The writer may own a bank that holds no complete frame.
    function automatic logic bank_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    // The reader may own a bank that holds a complete frame.
    function automatic logic bank_readable(input bank_state_t s);
        return (s == FULL) || (s == READING);
    endfunction

endpackage

// File: rtl/projection_frame_scheduler_raster_counter.sv
// Raster-order coordinate counter (x fastest, then y) with a linear word address
// kept alongside it, so no multiplier is needed for y*WIDTH + x.
// Ports:
//   clk, reset   clock; asynchronous active-low reset
//   step         advance one position
//   clear        return to (0,0) / address 0; has priority over step
//   x, y, addr   current position and its linear address
//   last         current position is (WIDTH-1, HEIGHT-1)
module projection_frame_scheduler_raster_counter
    import projection_frame_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned XW     = $clog2(WIDTH),
    parameter int unsigned YW     = $clog2(HEIGHT),
    parameter int unsigned AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (step) begin
            addr_d = addr_q + AW'(1);
            if (x_q == XMAX) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign addr = addr_q;
    assign last = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/projection_frame_scheduler.sv
// Ping-pong frame-buffer scheduler ahead of the barrel-projection math unit.
// Incoming AXIS pixels are written into one bank while raster (Math_X, Math_Y)
// read requests are issued over the other, full bank.
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   AXIS_IN_tvalid/tready       pixel input handshake
//   wr_en, wr_bank, wr_addr     bank write strobe, target bank and word address
//   Math_Valid/Math_Ready       coordinate handshake towards the math unit
//   Math_X, Math_Y, rd_bank     read coordinate and the bank it refers to
//   frame_done                  pulse in the cycle the last coordinate is accepted
module projection_frame_scheduler
    import projection_frame_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned XW     = $clog2(WIDTH),
    parameter int unsigned YW     = $clog2(HEIGHT),
    parameter int unsigned AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          AXIS_IN_tvalid,
    output logic          AXIS_IN_tready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          Math_Valid,
    input  logic          Math_Ready,
    output logic [XW-1:0] Math_X,
    output logic [YW-1:0] Math_Y,
    output logic          rd_bank,
    output logic          frame_done
);

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    // Low through reset and the first edge after release, so both handshakes
    // stay quiet until the block is actually running.
    logic run_q;
    logic wr_bank_q, rd_bank_q;

    logic wr_last, rd_last;
    logic rd_accept, wr_done, rd_done;
    logic [XW-1:0] wr_x_unused;
    logic [YW-1:0] wr_y_unused;
    logic [AW-1:0] rd_addr_unused;

    assign AXIS_IN_tready = run_q & bank_writable(bank_q[wr_bank_q]);
    assign Math_Valid     = run_q & bank_readable(bank_q[rd_bank_q]);

    assign wr_en     = AXIS_IN_tvalid & AXIS_IN_tready;
    assign rd_accept = Math_Valid & Math_Ready;
    assign wr_done   = wr_en & wr_last;
    assign rd_done   = rd_accept & rd_last;

    assign frame_done = rd_done;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;

    projection_frame_scheduler_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW),
        .AW     (AW)
    ) u_wr_counter (
        .clk   (clk),
        .reset (reset),
        .step  (wr_en),
        .clear (wr_done),
        .x     (wr_x_unused),
        .y     (wr_y_unused),
        .addr  (wr_addr),
        .last  (wr_last)
    );

    projection_frame_scheduler_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW),
        .AW     (AW)
    ) u_rd_counter (
        .clk   (clk),
        .reset (reset),
        .step  (rd_accept),
        .clear (rd_done),
        .x     (Math_X),
        .y     (Math_Y),
        .addr  (rd_addr_unused),
        .last  (rd_last)
    );

    // Writer events only touch a writable bank and reader events only a readable
    // one, so the two updates below can never land on the same bank.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bank_d[i] = bank_q[i];
            if (wr_en && (wr_bank_q == 1'(i))) begin
                bank_d[i] = wr_done ? FULL : FILLING;
            end
            if (Math_Valid && (rd_bank_q == 1'(i))) begin
                bank_d[i] = rd_done ? EMPTY : READING;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_q ^ wr_done;
            rd_bank_q <= rd_bank_q ^ rd_done;
        end
    end

    // Writer and reader never operate on the same bank.
    assert property (@(posedge clk) disable iff (!reset)
        !(wr_en && Math_Valid && (wr_bank_q == rd_bank_q)));

    assert property (@(posedge clk) disable iff (!reset)
        ((bank_q[wr_bank_q] == FILLING) && (bank_q[rd_bank_q] == READING))
            |-> (wr_bank_q != rd_bank_q));

endmodule

// File: tb/tb_projection_frame_scheduler.sv
// Self-checking bench for projection_frame_scheduler with a 4x3 frame.
// The reference model tracks frames rather than bank states: frames written
// (mwf), frames fully read (mrf) and the pixel position within each current
// frame. Frame k lives in bank k%2; the writer may proceed while fewer than two
// frames are buffered, the reader while a complete unread frame exists.
module tb_projection_frame_scheduler;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int AW = $clog2(N);

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic tvalid = 1'b0;
    logic mready = 1'b0;

    logic          tready, wr_en, wr_bank, mvalid, rd_bank, frame_done;
    logic [AW-1:0] wr_addr;
    logic [XW-1:0] mx;
    logic [YW-1:0] my;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    projection_frame_scheduler #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .AXIS_IN_tvalid (tvalid),
        .AXIS_IN_tready (tready),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .Math_Valid     (mvalid),
        .Math_Ready     (mready),
        .Math_X         (mx),
        .Math_Y         (my),
        .rd_bank        (rd_bank),
        .frame_done     (frame_done)
    );

    // ---------------- reference model ----------------
    int   mwf = 0, mrf = 0, mwpos = 0, mrpos = 0;
    logic mrun = 1'b0;
    logic m_tready, m_valid;

    assign m_tready = mrun && (mwf < mrf + 2);
    assign m_valid  = mrun && (mwf > mrf);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrun  <= 1'b0;
            mwf   <= 0;
            mrf   <= 0;
            mwpos <= 0;
            mrpos <= 0;
        end else begin
            mrun <= 1'b1;
            if (tvalid && m_tready) begin
                if (mwpos == N - 1) begin
                    mwpos <= 0;
                    mwf   <= mwf + 1;
                end else begin
                    mwpos <= mwpos + 1;
                end
            end
            if (m_valid && mready) begin
                if (mrpos == N - 1) begin
                    mrpos <= 0;
                    mrf   <= mrf + 1;
                end else begin
                    mrpos <= mrpos + 1;
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        check("tready", tready, m_tready);
        check("wr_en", wr_en, tvalid & m_tready);
        check("wr_bank", wr_bank, mwf % 2);
        check("wr_addr", wr_addr, mwpos);
        check("Math_Valid", mvalid, m_valid);
        check("rd_bank", rd_bank, mrf % 2);
        check("Math_X", mx, mrpos % W);
        check("Math_Y", my, mrpos / W);
        check("frame_done", frame_done, m_valid && mready && (mrpos == N - 1));
        if (wr_en && mvalid) check("bank_overlap", wr_bank != rd_bank, 1);
    endtask

    // ---------------- stimulus and directed checks ----------------
    int wq_addr[$];
    int wq_bank[$];
    int acc, done_at, fd, n, got, rf_start;

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Scenario 1: fill both banks with the reader stalled.
        #1 rst_n = 1'b0;
        #100;
        rst_n  = 1'b1;
        tvalid = 1'b1;
        mready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (wr_en) begin
                wq_addr.push_back(int'(wr_addr));
                wq_bank.push_back(int'(wr_bank));
            end
        end
        check("s1_write_count", wq_addr.size(), 2 * N);
        for (int i = 0; i < wq_addr.size() && i < 2 * N; i++) begin
            check("s1_addr", wq_addr[i], i % N);
            check("s1_bank", wq_bank[i], i / N);
        end
        check("s1_tready_low", tready, 0);
        check("s1_valid_high", mvalid, 1);
        check("s1_model_frames", mwf, 2);

        // Scenario 2: release the reader, one frame of raster coordinates.
        @(posedge clk);
        #1 mready = 1'b1;
        acc     = 0;
        done_at = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (mvalid && mready) begin
                check("s2_x", mx, acc % W);
                check("s2_y", my, acc / W);
                check("s2_rd_bank", rd_bank, 0);
                if (frame_done) done_at = acc;
                acc++;
            end
        end
        check("s2_done_on_12th", done_at, N - 1);
        @(negedge clk);
        check("s2_tready_after", tready, 1);
        check("s2_wr_bank_after", wr_bank, 0);
        check("s2_rd_bank_after", rd_bank, 1);

        // Scenario 4: writer and reader now run in lockstep; the second frame
        // completion after this point is bank 1 written with bank 0 released.
        fd = 0;
        for (int c = 0; c < 60 && fd < 2; c++) begin
            @(negedge clk);
            if (frame_done) fd++;
        end
        check("s4_frames", fd, 2);
        check("s4_same_cycle_wr_en", wr_en, 1);
        check("s4_same_cycle_addr", wr_addr, N - 1);
        check("s4_same_cycle_wr_bank", wr_bank, 1);
        check("s4_same_cycle_rd_bank", rd_bank, 0);
        @(negedge clk);
        check("s4_wr_bank", wr_bank, 0);
        check("s4_rd_bank", rd_bank, 1);
        check("s4_bank0_empty", tready, 1);
        check("s4_bank1_full", mvalid, 1);

        // Scenario 3: toggling Math_Ready, then fully random traffic.
        rf_start = mrf;
        fd       = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            tvalid = ($urandom_range(0, 3) != 0);
            if (c < 150) mready = (c % 2 == 0);
            else         mready = ($urandom_range(0, 2) != 0);
            if (frame_done) fd++;
        end
        check("s3_frame_count", fd, mrf - rf_start);

        // Scenario 5: reset after 5 writes and 3 reads.
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        tvalid = 1'b0;
        mready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        tvalid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < N; c++) begin
            @(negedge clk);
            if (wr_en) n++;
        end
        check("s5_fill", n, N);
        @(posedge clk);
        #1 mready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("s5_pre_addr", wr_addr, 4);
                check("s5_pre_wr_bank", wr_bank, 1);
                check("s5_pre_x", mx, 3);
                check("s5_pre_y", my, 0);
            end
            @(posedge clk);
            #1;
            if (i == 2) mready = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("s5_rst_tready", tready, 0);
        check("s5_rst_wr_en", wr_en, 0);
        check("s5_rst_wr_addr", wr_addr, 0);
        check("s5_rst_wr_bank", wr_bank, 0);
        check("s5_rst_valid", mvalid, 0);
        check("s5_rst_x", mx, 0);
        check("s5_rst_y", my, 0);
        check("s5_rst_rd_bank", rd_bank, 0);
        check("s5_rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (wr_en) begin
                got = 1;
                check("s5_first_addr", wr_addr, 0);
                check("s5_first_bank", wr_bank, 0);
            end
        end
        check("s5_first_write_seen", got, 1);
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (mvalid) begin
                got = 1;
                check("s5_first_x", mx, 0);
                check("s5_first_y", my, 0);
                check("s5_first_rd_bank", rd_bank, 0);
            end
        end
        check("s5_first_read_seen", got, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
